complex_subtractor_pipe_32b: RTL and testbench

//  Pipelined packed-complex subtractor R = A - B: the difference leg of the radix-2

---
 rtl/complex_subtractor_pipe_32b_if.sv | 25 ++
 rtl/complex_subtractor_pipe_32b.sv | 108 ++++++++++
 tb/tb_complex_subtractor_pipe_32b.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_subtractor_pipe_32b_if.sv
// Handshake/data bundle for the pipelined packed-complex subtractor.
// The slave modport is the subtractor side, the master modport is the driver side.
interface complex_subtractor_pipe_32b_if #(
  parameter int DATA_W = 16
);
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [2*DATA_W-1:0]   A32;
  logic [2*DATA_W-1:0]   B32;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [2*DATA_W-1:0]   R32;
  logic [1:0]            BORROW_32;
  logic [1:0]            OVF_32;

  modport slave (
    input  IN_VALID, A32, B32, OUT_READY,
    output IN_READY, OUT_VALID, R32, BORROW_32, OVF_32
  );

  modport master (
    output IN_VALID, A32, B32, OUT_READY,
    input  IN_READY, OUT_VALID, R32, BORROW_32, OVF_32
  );
endinterface

// File: rtl/complex_subtractor_pipe_32b.sv
// Two-stage pipelined packed-complex subtractor R = A - B, operands packed
// {real, imag}, two's complement, valid/ready flow control on both sides.
// Optional build macro: CSUB_SATURATE_EN -- clamps an overflowing component to
// 0x7FFF/0x8000 (sign of A); otherwise components wrap modulo 2^DATA_W.
module complex_subtractor_pipe_32b #(
  parameter int DATA_W = 16
) (
  input logic CLK,
  input logic RST,
  complex_subtractor_pipe_32b_if.slave bus
);
  localparam int PW = 2 * DATA_W;

  // Stage 1 holds A and the inverted B so stage 2 only needs an adder.
  logic          s1_valid;
  logic [PW-1:0] s1_a;
  logic [PW-1:0] s1_nb;

  // Stage 2 holds the finished result and status flags.
  logic          s2_valid;
  logic [PW-1:0] s2_r;
  logic [1:0]    s2_borrow;
  logic [1:0]    s2_ovf;

  logic          s2_load;
  logic          s1_move;
  logic          s1_load;
  logic          in_xfer;

  logic [PW-1:0] r_next;
  logic [1:0]    borrow_next;
  logic [1:0]    ovf_next;

  // Each stage advances when it is empty or its content is leaving.
  assign s2_load = ~s2_valid | bus.OUT_READY;
  assign s1_move = s1_valid & s2_load;
  assign s1_load = ~s1_valid | s1_move;
  assign in_xfer = bus.IN_VALID & s1_load;

  // Per-component subtract: real and imag are separate adders, no carry crosses.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_comp
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] nb;
    logic [DATA_W:0]   sum;
    logic              a_sign;
    logic              b_sign;
    logic              r_sign;
    logic              ovf;

    assign a      = s1_a[gi*DATA_W +: DATA_W];
    assign nb     = s1_nb[gi*DATA_W +: DATA_W];
    assign sum    = {1'b0, a} + {1'b0, nb} + {{DATA_W{1'b0}}, 1'b1};
    assign a_sign = a[DATA_W-1];
    assign b_sign = ~nb[DATA_W-1];
    assign r_sign = sum[DATA_W-1];
    assign ovf    = (a_sign != b_sign) & (r_sign != a_sign);

    assign borrow_next[gi] = ~sum[DATA_W];
    assign ovf_next[gi]    = ovf;

`ifdef CSUB_SATURATE_EN
    assign r_next[gi*DATA_W +: DATA_W] =
      !ovf   ? sum[DATA_W-1:0] :
      a_sign ? {1'b1, {(DATA_W-1){1'b0}}} :
               {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign r_next[gi*DATA_W +: DATA_W] = sum[DATA_W-1:0];
`endif
  end

  // Stage 1: capture A and ~B on an input transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_nb    <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.IN_VALID;
      if (bus.IN_VALID) begin
        s1_a  <= bus.A32;
        s1_nb <= ~bus.B32;
      end
    end
  end

  // Stage 2: register difference, borrow and overflow; held while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid  <= 1'b0;
      s2_r      <= '0;
      s2_borrow <= '0;
      s2_ovf    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_r      <= r_next;
        s2_borrow <= borrow_next;
        s2_ovf    <= ovf_next;
      end
    end
  end

  assign bus.IN_READY  = ~s1_valid | ~s2_valid | bus.OUT_READY;
  assign bus.OUT_VALID = s2_valid;
  assign bus.R32       = s2_r;
  assign bus.BORROW_32 = s2_borrow;
  assign bus.OVF_32    = s2_ovf;
endmodule

// File: tb/tb_complex_subtractor_pipe_32b.sv
// Scoreboard bench for complex_subtractor_pipe_32b: the driver pushes expected
// results from an arithmetic reference model, a monitor pops on each output transfer.
module tb_complex_subtractor_pipe_32b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   toggle_on = 1'b0;

  typedef struct {
    logic [31:0] r;
    logic [1:0]  bo;
    logic [1:0]  ov;
    int          cyc;
  } exp_t;

  exp_t q[$];

  complex_subtractor_pipe_32b_if #(.DATA_W(16)) bus();

  complex_subtractor_pipe_32b #(.DATA_W(16)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: signed integer subtraction per component, range check for overflow,
  // unsigned compare for borrow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      logic [15:0] ac;
      logic [15:0] bc;
      int sa;
      int sb;
      int d;
      logic [15:0] rc;
      ac = a[c*16 +: 16];
      bc = b[c*16 +: 16];
      sa = int'($signed(ac));
      sb = int'($signed(bc));
      d  = sa - sb;
      e.ov[c] = (d > 32767) || (d < -32768);
      e.bo[c] = (ac < bc);
      rc = d[15:0];
`ifdef CSUB_SATURATE_EN
      if (e.ov[c]) rc = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
      e.r[c*16 +: 16] = rc;
    end
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: compare on every output transfer, check held outputs stay stable.
  logic        held = 1'b0;
  logic [31:0] held_r;
  logic [1:0]  held_bo;
  logic [1:0]  held_ov;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (bus.OUT_VALID && held) begin
        tests++;
        if (bus.R32 !== held_r || bus.BORROW_32 !== held_bo || bus.OVF_32 !== held_ov) begin
          fails++;
          $display("FAIL hold_stable: R=%h B=%b O=%b required R=%h B=%b O=%b",
                   bus.R32, bus.BORROW_32, bus.OVF_32, held_r, held_bo, held_ov);
        end
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: R=%h with no pending result", bus.R32);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.R32 !== e.r || bus.BORROW_32 !== e.bo || bus.OVF_32 !== e.ov) begin
            fails++;
            $display("FAIL result: R=%h B=%b O=%b required R=%h B=%b O=%b",
                     bus.R32, bus.BORROW_32, bus.OVF_32, e.r, e.bo, e.ov);
          end else begin
            $display("[TB] out R=%h B=%b O=%b", bus.R32, bus.BORROW_32, bus.OVF_32);
          end
          if (lat_mode) begin
            tests++;
            if (cyc - e.cyc != 2) begin
              fails++;
              $display("FAIL latency: got %0d cycles required 2", cyc - e.cyc);
            end
          end
        end
      end
      held    = bus.OUT_VALID && !bus.OUT_READY;
      held_r  = bus.R32;
      held_bo = bus.BORROW_32;
      held_ov = bus.OVF_32;
    end
  end

  // Random OUT_READY for the soak phase.
  always @(posedge clk) begin
    if (toggle_on) begin
      #1;
      if (toggle_on) bus.OUT_READY = $urandom_range(0, 1) != 0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and hold it until accepted (called at posedge+1).
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   waited;
    bit   done;
    waited = 0;
    done = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.A32 = a;
    bus.B32 = b;
    while (!done) begin
      @(negedge clk);
      if (bus.IN_READY) begin
        e = model(a, b);
        e.cyc = cyc;
        q.push_back(e);
        $display("[TB] in  A=%h B=%h", a, b);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          tests++;
          fails++;
          $display("FAIL accept_timeout: IN_READY=0 for %0d cycles required accept", waited);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.IN_VALID = 1'b0;
    if (lat_mode) begin
      tests++;
      if (waited != 0) begin
        fails++;
        $display("FAIL throughput: stalled %0d cycles required 0", waited);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      sync();
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results pending required 0", q.size());
    end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (bus.OUT_VALID !== 1'b0 || bus.R32 !== 32'h0 || bus.IN_READY !== 1'b1) begin
      fails++;
      $display("FAIL %s: OUT_VALID=%b R=%h IN_READY=%b required 0 00000000 1",
               name, bus.OUT_VALID, bus.R32, bus.IN_READY);
    end
  endtask

  initial begin
    bus.IN_VALID  = 1'b0;
    bus.A32       = '0;
    bus.B32       = '0;
    bus.OUT_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.BORROW_32 !== 2'b00 || bus.OVF_32 !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags: B=%b O=%b required 00 00", bus.BORROW_32, bus.OVF_32);
    end
    rst = 1'b0;
    sync();
    check_idle("reset_state");

    // Directed basic and overflow vectors.
    bus.OUT_READY = 1'b1;
    send(32'h0005_0003, 32'h0002_0004);
    send(32'h7FFF_8000, 32'hFFFF_0001);
    send(32'h8000_0000, 32'h0000_0000);
    send(32'h0000_8000, 32'h8000_7FFF);
    drain();

    // Backpressure: two accepts fill the pipe, then IN_READY must drop.
    bus.OUT_READY = 1'b0;
    send(32'h1111_2222, 32'h0101_0202);
    send(32'h3333_4444, 32'h0303_0404);
    @(negedge clk);
    tests++;
    if (bus.IN_READY !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_ready: IN_READY=%b required 0", bus.IN_READY);
    end
    sync();
    fork
      begin
        send(32'h5555_6666, 32'h0505_0606);
        send(32'h7777_8888, 32'h0707_0808);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.OUT_READY = 1'b1;
      end
    join
    drain();

    // Full throughput with latency check.
    lat_mode = 1'b1;
    for (int i = 0; i < 64; i++) send($urandom, $urandom);
    drain();
    lat_mode = 1'b0;

    // Reset with both stages full: nothing old may emerge afterwards.
    bus.OUT_READY = 1'b0;
    send(32'hAAAA_BBBB, 32'h1234_5678);
    send(32'hCCCC_DDDD, 32'h8765_4321);
    rst = 1'b1;
    q.delete();
    sync();
    rst = 1'b0;
    check_idle("reset_midstream");
    bus.OUT_READY = 1'b1;
    repeat (5) sync();
    check_idle("after_reset");

    // Soak with random OUT_READY and random input gaps.
    toggle_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) sync();
      send($urandom, $urandom);
    end
    toggle_on = 1'b0;
    sync();
    bus.OUT_READY = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
